encoder_8x3_handshake: RTL and testbench

- Registered 8-to-3 priority encoder with request latching and a valid/ack handshake. It is the inverse of the team's 3x8 decoder.
- Eight request strobes are captured into a sticky pending register. The highest-priority pending line is presented as a 3-bit code. The code is held until the consumer acknowledges it, then that request is retired.
- Sits between request sources (buttons, peripheral strobes) and a consumer, which may itself drive a Decoder_3x8.

---
 rtl/encoder_8x3_handshake_if.sv | 28 ++
 rtl/encoder_8x3_handshake.sv | 94 +++++++++
 tb/tb_encoder_8x3_handshake.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/encoder_8x3_handshake_if.sv
// Bus between request sources / consumer and the 8-to-3 handshake encoder.
// The encoder takes the slave view; the driving side takes the master view.
interface encoder_8x3_handshake_if;
    logic [7:0] D;
    logic       ack;
    logic [2:0] A;
    logic       valid;
    logic [7:0] pending;
    logic       drop;

    modport master (
        output D,
        output ack,
        input  A,
        input  valid,
        input  pending,
        input  drop
    );

    modport slave (
        input  D,
        input  ack,
        output A,
        output valid,
        output pending,
        output drop
    );
endinterface

// File: rtl/encoder_8x3_handshake.sv
// Registered 8-to-3 priority encoder: sticky request latching, grant held
// until acknowledged, then the granted line is retired.
module encoder_8x3_handshake #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    encoder_8x3_handshake_if.slave        bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_reg;
    logic [7:0]  pending_reg;
    logic [2:0]  a_reg;
    logic        valid_reg;
    logic        drop_reg;

    logic        retire;
    logic [7:0]  clr;
    logic [7:0]  pending_next;
    logic        drop_next;
    logic [2:0]  prio_idx;

    // Only a live grant can be retired; ack while idle is ignored.
    assign retire = (state_reg == HOLD) && bus.ack;

    for (genvar gi = 0; gi < 8; gi++) begin : g_clr
        assign clr[gi] = retire && (a_reg == 3'(gi));
    end

    // A new strobe on the retiring line wins over the clear.
    assign pending_next = (pending_reg & ~clr) | bus.D;
    assign drop_next    = |(bus.D & pending_reg & ~clr);

    always_comb begin
        prio_idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++) begin
                if (pending_reg[i]) begin
                    prio_idx = i[2:0];
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_reg[i]) begin
                    prio_idx = i[2:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= 8'h00;
            a_reg       <= 3'b000;
            valid_reg   <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            drop_reg    <= drop_next;
            case (state_reg)
                IDLE: begin
                    // Grant from the registered pending set, not this cycle's D.
                    if (|pending_reg) begin
                        a_reg     <= prio_idx;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.ack) begin
                        valid_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.A       = a_reg;
    assign bus.valid   = valid_reg;
    assign bus.pending = pending_reg;
    assign bus.drop    = drop_reg;

endmodule

// File: tb/tb_encoder_8x3_handshake.sv
// Directed test of encoder_8x3_handshake; both priority polarities run in
// lockstep from the same stimulus.
module tb_encoder_8x3_handshake;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    encoder_8x3_handshake_if b1 ();
    encoder_8x3_handshake_if b0 ();

    encoder_8x3_handshake #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    encoder_8x3_handshake #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    task automatic drive(input logic [7:0] d, input logic a);
        b1.D = d;  b1.ack = a;
        b0.D = d;  b0.ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [2:0] a);
        chk({tag, "_valid"}, {7'd0, b1.valid}, {7'd0, v});
        if (v) chk({tag, "_A"}, {5'd0, b1.A}, {5'd0, a});
    endtask

    initial begin
        // Reset held with hostile inputs
        rst = 1'b1;
        drive(8'hFF, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        drive(8'h00, 1'b0);
        chk("rst_pending", b1.pending, 8'h00);
        chk("rst_valid",   {7'd0, b1.valid}, 8'h00);
        chk("rst_A",       {5'd0, b1.A}, 8'h00);
        chk("rst_drop",    {7'd0, b1.drop}, 8'h00);

        // Single request on line 5
        drive(8'h20, 1'b0);
        tick();
        chk("single_pending", b1.pending, 8'h20);
        chk("single_valid0",  {7'd0, b1.valid}, 8'h00);
        drive(8'h00, 1'b0);
        tick();
        chk_grant("single_grant", 1'b1, 3'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_grant("single_hold", 1'b1, 3'd5);
        end
        drive(8'h00, 1'b1);
        tick();
        chk_grant("single_ack", 1'b0, 3'd0);
        chk("single_ack_pending", b1.pending, 8'h00);
        drive(8'h00, 1'b0);
        tick();
        chk_grant("single_idle", 1'b0, 3'd0);

        // Priority order, ack held high
        drive(8'h85, 1'b1);
        tick();
        chk("prio_pending", b1.pending, 8'h85);
        drive(8'h00, 1'b1);
        tick();
        chk_grant("prio_g1", 1'b1, 3'd7);
        chk("prio_lo_g1", {5'd0, b0.A}, 8'd0);
        chk("prio_lo_v1", {7'd0, b0.valid}, 8'd1);
        tick();
        chk_grant("prio_i1", 1'b0, 3'd0);
        chk("prio_pend1", b1.pending, 8'h05);
        chk("prio_lo_pend1", b0.pending, 8'h84);
        tick();
        chk_grant("prio_g2", 1'b1, 3'd2);
        chk("prio_lo_g2", {5'd0, b0.A}, 8'd2);
        tick();
        chk_grant("prio_i2", 1'b0, 3'd0);
        tick();
        chk_grant("prio_g3", 1'b1, 3'd0);
        chk("prio_lo_g3", {5'd0, b0.A}, 8'd7);
        tick();
        chk_grant("prio_i3", 1'b0, 3'd0);
        chk("prio_end_pending", b1.pending, 8'h00);
        chk("prio_lo_end_pending", b0.pending, 8'h00);
        drive(8'h00, 1'b0);
        tick();
        chk_grant("prio_quiet", 1'b0, 3'd0);

        // No preemption
        drive(8'h08, 1'b0);
        tick();
        drive(8'h00, 1'b0);
        tick();
        chk_grant("nopre_grant", 1'b1, 3'd3);
        drive(8'h40, 1'b0);
        tick();
        chk_grant("nopre_hold", 1'b1, 3'd3);
        chk("nopre_pending", b1.pending, 8'h48);
        drive(8'h00, 1'b0);
        tick();
        chk_grant("nopre_hold2", 1'b1, 3'd3);
        drive(8'h00, 1'b1);
        tick();
        chk_grant("nopre_ack", 1'b0, 3'd0);
        chk("nopre_ack_pending", b1.pending, 8'h40);
        drive(8'h00, 1'b0);
        tick();
        chk_grant("nopre_next", 1'b1, 3'd6);
        drive(8'h00, 1'b1);
        tick();
        chk("nopre_end_pending", b1.pending, 8'h00);
        drive(8'h00, 1'b0);

        // Duplicate strobe
        drive(8'h10, 1'b0);
        tick();
        chk("dup_drop0", {7'd0, b1.drop}, 8'h00);
        tick();
        chk("dup_drop1", {7'd0, b1.drop}, 8'h01);
        chk_grant("dup_grant", 1'b1, 3'd4);
        drive(8'h00, 1'b0);
        tick();
        chk("dup_drop_pulse", {7'd0, b1.drop}, 8'h00);
        chk("dup_pending", b1.pending, 8'h10);
        drive(8'h00, 1'b1);
        tick();
        chk("dup_end_pending", b1.pending, 8'h00);
        drive(8'h00, 1'b0);

        // Set wins over ack clear
        drive(8'h02, 1'b0);
        tick();
        drive(8'h00, 1'b0);
        tick();
        chk_grant("setwin_grant", 1'b1, 3'd1);
        drive(8'h02, 1'b1);
        tick();
        chk_grant("setwin_ack", 1'b0, 3'd0);
        chk("setwin_pending", b1.pending, 8'h02);
        chk("setwin_drop", {7'd0, b1.drop}, 8'h00);
        drive(8'h00, 1'b0);
        tick();
        chk_grant("setwin_regrant", 1'b1, 3'd1);
        drive(8'h00, 1'b1);
        tick();
        chk("setwin_end_pending", b1.pending, 8'h00);
        drive(8'h00, 1'b0);

        // Reset mid-handshake
        drive(8'h2C, 1'b0);
        tick();
        drive(8'h00, 1'b0);
        tick();
        chk_grant("midrst_grant", 1'b1, 3'd5);
        chk("midrst_pending", b1.pending, 8'h2C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_grant("midrst_valid", 1'b0, 3'd0);
        chk("midrst_A", {5'd0, b1.A}, 8'h00);
        chk("midrst_pend0", b1.pending, 8'h00);
        tick();
        tick();
        chk_grant("midrst_quiet", 1'b0, 3'd0);
        chk("midrst_quiet_pending", b1.pending, 8'h00);
        chk("midrst_lo_valid", {7'd0, b0.valid}, 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
